led_pattern_engine: RTL and testbench

- Multi-channel LED pattern generator; the generalised successor to the single-LED divided-clock SOS blinker.
- Runs entirely on the PLL output clock: internal tick prescaler, shared PWM counter, and per-channel pattern/brightness/breathing engines.
- Programmed at runtime through a valid/ready config port.
- Sits between the PLL clock/reset and the board LED pins.

---
 rtl/led_pattern_engine.sv | 157 +++++++++++++++
 tb/tb_led_pattern_engine.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_engine.sv
// Multi-channel LED pattern engine on the PLL clock. A shared tick prescaler
// paces pattern stepping and breathing; a shared free-running PWM counter sets
// brightness. Channels are configured at runtime through a valid/ready port.
module led_pattern_engine #(
  parameter int CHANNELS = 4,
  parameter int PAT_LEN  = 16,
  parameter int REP_W    = 4,
  parameter int PWM_W    = 8,
  parameter int PRE_W    = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PRE_W-1:0]    prescale,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [3:0]          cfg_chan,
  input  logic [1:0]          cfg_mode,
  input  logic [PAT_LEN-1:0]  cfg_pattern,
  input  logic [REP_W-1:0]    cfg_repeat,
  input  logic [PWM_W-1:0]    cfg_duty,
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] done
);

  localparam int IDX_W = $clog2(PAT_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_LEN - 1);

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_STATIC  = 2'd1;
  localparam logic [1:0] MODE_PATTERN = 2'd2;
  localparam logic [1:0] MODE_BREATHE = 2'd3;

  // Per-channel state; mode is the channel FSM state, the rest is its datapath.
  // rep_left == 0 means the pattern loops forever.
  typedef struct packed {
    logic [1:0]         mode;
    logic [PAT_LEN-1:0] pattern;
    logic [PWM_W-1:0]   duty;
    logic [REP_W-1:0]   rep_left;
    logic [IDX_W-1:0]   idx;
    logic [PWM_W-1:0]   level;
    logic               down;
  } chan_t;

  chan_t               ch_q [CHANNELS];
  chan_t               ch_d [CHANNELS];
  logic [CHANNELS-1:0] led_d;
  logic [CHANNELS-1:0] done_d;

  logic [PRE_W-1:0]    pre_cnt;
  logic [PWM_W-1:0]    pwm;
  logic                tick;
  logic                cfg_fire;

  // Handshake: a config write transfers on a clk edge where cfg_valid and
  // cfg_ready are both high; cfg_ready is high whenever not in reset, and the
  // sender holds all cfg_* fields stable while cfg_valid is high.
  assign cfg_fire = cfg_valid && cfg_ready;

  // >= rather than == so lowering prescale never forces a full-range wrap.
  assign tick = (pre_cnt >= prescale);

  // Tick prescaler, PWM counter and config-ready flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt   <= '0;
      pwm       <= '0;
      cfg_ready <= 1'b0;
    end else begin
      pre_cnt   <= tick ? '0 : pre_cnt + 1'b1;
      pwm       <= pwm + 1'b1;
      cfg_ready <= 1'b1;
    end
  end

  // State register: channel state plus registered LED and done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) ch_q[c] <= '0;
      led  <= '0;
      done <= '0;
    end else begin
      ch_q <= ch_d;
      led  <= led_d;
      done <= done_d;
    end
  end

  // Next-state: a config write for a channel overrides any tick on that edge.
  always_comb begin
    ch_d   = ch_q;
    done_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (cfg_fire && (cfg_chan == 4'(c))) begin
        ch_d[c].mode     = cfg_mode;
        ch_d[c].pattern  = cfg_pattern;
        ch_d[c].duty     = cfg_duty;
        ch_d[c].rep_left = cfg_repeat;
        ch_d[c].idx      = '0;
        ch_d[c].level    = '0;
        ch_d[c].down     = 1'b0;
      end else if (tick) begin
        case (ch_q[c].mode)
          MODE_PATTERN: begin
            if (ch_q[c].idx != IDX_LAST) begin
              ch_d[c].idx = ch_q[c].idx + 1'b1;
            end else begin
              ch_d[c].idx = '0;
              if (ch_q[c].rep_left == REP_W'(1)) begin
                done_d[c]    = 1'b1;
                ch_d[c].mode = MODE_OFF;
              end else if (ch_q[c].rep_left != '0) begin
                ch_d[c].rep_left = ch_q[c].rep_left - 1'b1;
              end
            end
          end
          MODE_BREATHE: begin
            if (ch_q[c].duty == '0) begin
              ch_d[c].level = '0;
              ch_d[c].down  = 1'b0;
            end else if (!ch_q[c].down) begin
              // Clamp at the peak so level never passes duty.
              if (ch_q[c].level >= ch_q[c].duty - 1'b1) begin
                ch_d[c].level = ch_q[c].duty;
                ch_d[c].down  = 1'b1;
              end else begin
                ch_d[c].level = ch_q[c].level + 1'b1;
              end
            end else begin
              if (ch_q[c].level <= PWM_W'(1)) begin
                ch_d[c].level = '0;
                ch_d[c].down  = 1'b0;
              end else begin
                ch_d[c].level = ch_q[c].level - 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Output decode: LED drive for the next cycle from the current channel state.
  always_comb begin
    led_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      case (ch_q[c].mode)
        MODE_STATIC:  led_d[c] = (pwm < ch_q[c].duty);
        MODE_PATTERN: led_d[c] = ch_q[c].pattern[ch_q[c].idx] && (pwm < ch_q[c].duty);
        MODE_BREATHE: led_d[c] = (pwm < ch_q[c].level);
        default:      led_d[c] = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed bench for led_pattern_engine: reset, pattern timing with done,
// static duty, breathing, write-vs-tick priority, out-of-range channel, and
// reset in the middle of a finite pattern.
module tb_led_pattern_engine;

  localparam int CHANNELS = 4;
  localparam int PAT_LEN  = 16;
  localparam int REP_W    = 4;
  localparam int PWM_W    = 8;
  localparam int PRE_W    = 24;

  logic                clk;
  logic                rst;
  logic [PRE_W-1:0]    prescale;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [3:0]          cfg_chan;
  logic [1:0]          cfg_mode;
  logic [PAT_LEN-1:0]  cfg_pattern;
  logic [REP_W-1:0]    cfg_repeat;
  logic [PWM_W-1:0]    cfg_duty;
  logic [CHANNELS-1:0] led;
  logic [CHANNELS-1:0] done;

  int total = 0;
  int bad   = 0;

  led_pattern_engine #(
    .CHANNELS(CHANNELS), .PAT_LEN(PAT_LEN), .REP_W(REP_W),
    .PWM_W(PWM_W), .PRE_W(PRE_W)
  ) dut (
    .clk(clk), .rst(rst), .prescale(prescale),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan),
    .cfg_mode(cfg_mode), .cfg_pattern(cfg_pattern), .cfg_repeat(cfg_repeat),
    .cfg_duty(cfg_duty), .led(led), .done(done)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One config transfer; called just after an edge, returns just after the
  // edge that accepted it.
  task automatic cfg_write(input logic [3:0] chan, input logic [1:0] mode,
                           input logic [15:0] pat, input logic [3:0] rep,
                           input logic [7:0] duty);
    cfg_valid   = 1'b1;
    cfg_chan    = chan;
    cfg_mode    = mode;
    cfg_pattern = pat;
    cfg_repeat  = rep;
    cfg_duty    = duty;
    step(1);
    cfg_valid   = 1'b0;
  endtask

  task automatic count_led(input int ch, input int n, output int ones);
    ones = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (led[ch]) ones++;
    end
  endtask

  logic [7:0] exp_lv [9];
  int ones;
  int seen;

  initial begin
    exp_lv = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd1};
    rst = 1'b1; prescale = 24'd3; cfg_valid = 1'b0; cfg_chan = '0;
    cfg_mode = '0; cfg_pattern = '0; cfg_repeat = '0; cfg_duty = '0;

    // Reset release
    step(3);
    chk("rst_ready", 32'(cfg_ready), 0);
    chk("rst_led",   32'(led), 0);
    chk("rst_done",  32'(done), 0);
    rst = 1'b0;
    step(1);                                        // E1
    chk("ready_after_release", 32'(cfg_ready), 1);
    chk("led_after_release",   32'(led), 0);

    // Pattern 0x0005, 4 clks per bit, one repetition; write lands on the E4 tick
    step(2);                                        // E3
    cfg_write(4'd0, 2'd2, 16'h0005, 4'd1, 8'd255);  // accepted E4
    chk("pat_e4", 32'(led[0]), 0);
    step(1); chk("pat_bit0_start", 32'(led[0]), 1); // E5
    step(3); chk("pat_bit0_end",   32'(led[0]), 1); // E8
    step(1); chk("pat_bit1_start", 32'(led[0]), 0); // E9
    step(3); chk("pat_bit1_end",   32'(led[0]), 0); // E12
    step(1); chk("pat_bit2_start", 32'(led[0]), 1); // E13
    step(3); chk("pat_bit2_end",   32'(led[0]), 1); // E16
    step(1); chk("pat_bit3_start", 32'(led[0]), 0); // E17
    step(50);                                       // E67
    chk("pat_done_early", 32'(done), 0);
    step(1);                                        // E68
    chk("pat_done_pulse", 32'(done), 32'h1);
    step(1);                                        // E69
    chk("pat_done_single", 32'(done), 0);
    chk("pat_led_off", 32'(led[0]), 0);
    step(20);
    chk("pat_stays_off", 32'(led[0]), 0);

    // Static duty over a full PWM period
    cfg_write(4'd1, 2'd1, 16'h0000, 4'd0, 8'd64);
    step(1);
    count_led(1, 256, ones); chk("static_64", ones, 64);
    cfg_write(4'd1, 2'd1, 16'h0000, 4'd0, 8'd0);
    step(1);
    count_led(1, 256, ones); chk("static_0", ones, 0);
    cfg_write(4'd1, 2'd1, 16'h0000, 4'd0, 8'd255);
    step(1);
    count_led(1, 256, ones); chk("static_255", ones, 255);

    // Breathe with a tick every clk
    prescale = 24'd0;
    cfg_write(4'd2, 2'd3, 16'h0000, 4'd0, 8'd4);
    chk("breathe_start", 32'(dut.ch_q[2].level), 0);
    for (int i = 0; i < 9; i++) begin
      step(1);
      chk("breathe_level", 32'(dut.ch_q[2].level), 32'(exp_lv[i]));
    end
    cfg_write(4'd2, 2'd3, 16'h0000, 4'd0, 8'd0);
    step(3);
    chk("breathe_duty0", 32'(dut.ch_q[2].level), 0);
    cfg_write(4'd2, 2'd0, 16'h0000, 4'd0, 8'd0);

    // Write and tick on the same edge; pre_cnt is 0 here
    prescale = 24'd3;
    cfg_write(4'd3, 2'd2, 16'hFFFF, 4'd0, 8'd255);  // P+1
    cfg_write(4'd0, 2'd2, 16'h00F0, 4'd0, 8'd255);  // P+2
    step(2);                                        // P+4 tick
    chk("tick_idx_ch0", 32'(dut.ch_q[0].idx), 1);
    chk("tick_idx_ch3", 32'(dut.ch_q[3].idx), 1);
    step(3);                                        // P+7
    cfg_write(4'd0, 2'd2, 16'h00F0, 4'd0, 8'd255);  // P+8 tick
    chk("same_edge_ch0_idx", 32'(dut.ch_q[0].idx), 0);
    chk("same_edge_ch3_idx", 32'(dut.ch_q[3].idx), 2);

    // Out-of-range channel
    cfg_write(4'd0, 2'd0, 16'h0000, 4'd0, 8'd0);
    cfg_write(4'd1, 2'd0, 16'h0000, 4'd0, 8'd0);
    cfg_write(4'd3, 2'd0, 16'h0000, 4'd0, 8'd0);
    step(2);
    chk("all_off", 32'(led), 0);
    cfg_write(4'd7, 2'd1, 16'h0000, 4'd0, 8'd255);
    chk("chan7_ready", 32'(cfg_ready), 1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (led != '0 || done != '0) seen++;
    end
    chk("chan7_no_effect", seen, 0);

    // Finite repeat of two, tick every clk
    prescale = 24'd0;
    cfg_write(4'd1, 2'd2, 16'h0001, 4'd2, 8'd255);  // W
    step(16); chk("rep2_no_done_first", 32'(done), 0);
    step(15); chk("rep2_no_done_early", 32'(done), 0);
    step(1);  chk("rep2_done", 32'(done), 32'h2);
    step(1);  chk("rep2_done_clear", 32'(done), 0);
    chk("rep2_led_off", 32'(led[1]), 0);

    // Reset in the middle of a finite pattern
    cfg_write(4'd0, 2'd2, 16'hFFFF, 4'd3, 8'd255);
    step(10);
    rst = 1'b1;
    step(2);
    chk("midrst_led",   32'(led), 0);
    chk("midrst_done",  32'(done), 0);
    chk("midrst_ready", 32'(cfg_ready), 0);
    chk("midrst_mode",  32'(dut.ch_q[0].mode), 0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (led != '0 || done != '0) seen++;
    end
    chk("midrst_quiet", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
